// File: rtl/sar_conv_sequencer_if.sv
// Result stream between the SAR conversion sequencer and its consumer.
//   result        averaged conversion code
//   result_valid  result register holds an unconsumed value
//   result_ready  consumer accepts the result this cycle
// master: the sequencer (drives result/result_valid, samples result_ready)
// slave : the consumer
interface sar_conv_sequencer_if #(
  parameter int unsigned N_BITS = 12
) ();
  logic [N_BITS-1:0] result;
  logic              result_valid;
  logic              result_ready;

  modport master (
    output result,
    output result_valid,
    input  result_ready
  );

  modport slave (
    input  result,
    input  result_valid,
    output result_ready
  );
endinterface

// File: rtl/sar_conv_sequencer.sv
// Conversion controller for the SAR ADC core.
// Holds the SAR in sampling (sar_rst=1) for max(sample_cycles,1) cycles, releases it,
// waits for EOC, accumulates sar_dtop over 2**AVG_LOG2 conversions and publishes the
// truncated average through a one-entry valid/ready output register. Single-shot
// (start) and continuous (cont_en) operation; sticky overrun and timeout flags.
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   start          single-shot request, honoured only in IDLE
//   cont_en        continuous mode level
//   sample_cycles  sampling time in cycles (0 behaves as 1), sampled on SAMPLE entry
//   clr_flags      clears overrun and timeout_err (wins over a same-cycle set)
//   sar_state      SAR status: 0=BUSY, 1=EOC, 2=SAMPLING
//   sar_dtop       SAR code, valid while sar_state==EOC
//   sar_rst        holds SAR in sampling; low only while converting
//   res            result stream (master side)
//   busy           sequencer not idle
//   overrun        sticky: an averaged result was dropped
//   timeout_err    sticky: EOC not seen within TIMEOUT cycles of conversion
module sar_conv_sequencer #(
  parameter int unsigned N_BITS   = 12,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned TIMEOUT  = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                cont_en,
  input  logic [SAMPLE_W-1:0] sample_cycles,
  input  logic                clr_flags,
  input  logic [1:0]          sar_state,
  input  logic [N_BITS-1:0]   sar_dtop,
  output logic                sar_rst,
  sar_conv_sequencer_if.master res,
  output logic                busy,
  output logic                overrun,
  output logic                timeout_err
);

  localparam int unsigned AW   = N_BITS + AVG_LOG2;
  localparam int unsigned CW   = AVG_LOG2 + 1;
  localparam int unsigned TW   = $clog2(TIMEOUT);
  localparam int unsigned NAVG = 1 << AVG_LOG2;

  typedef enum logic [1:0] {
    SAR_BUSY     = 2'd0,
    SAR_EOC      = 2'd1,
    SAR_SAMPLING = 2'd2
  } sar_code_e;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    CONVERT,
    DONE
  } state_e;

  state_e              state;
  logic [SAMPLE_W-1:0] samp_cnt;
  logic [TW-1:0]       timer;
  logic [AW-1:0]       acc;
  logic [CW-1:0]       conv_cnt;

  logic [SAMPLE_W-1:0] samp_load;
  logic                eoc;
  logic [AW-1:0]       acc_next;
  logic [N_BITS-1:0]   avg;
  logic                last_conv;
  logic                out_free;

  always_comb begin
    samp_load = (sample_cycles == '0) ? SAMPLE_W'(1) : sample_cycles;
    eoc       = (sar_state == SAR_EOC);
    acc_next  = acc + AW'(sar_dtop);
    avg       = acc[AW-1:AVG_LOG2];
    last_conv = (conv_cnt == CW'(NAVG - 1));
    // Output register can take a new value if empty or being drained this cycle.
    out_free  = !res.result_valid || res.result_ready;
  end

  // sar_rst is registered alongside the state so that it is low exactly while in CONVERT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      sar_rst          <= 1'b1;
      res.result       <= '0;
      res.result_valid <= 1'b0;
      busy             <= 1'b0;
      overrun          <= 1'b0;
      timeout_err      <= 1'b0;
      samp_cnt         <= '0;
      timer            <= '0;
      acc              <= '0;
      conv_cnt         <= '0;
    end else begin
      if (res.result_valid && res.result_ready) begin
        res.result_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          sar_rst  <= 1'b1;
          acc      <= '0;
          conv_cnt <= '0;
          timer    <= '0;
          if (start || cont_en) begin
            state    <= SAMPLE;
            busy     <= 1'b1;
            samp_cnt <= samp_load;
          end
        end

        SAMPLE: begin
          sar_rst <= 1'b1;
          if (samp_cnt <= SAMPLE_W'(1)) begin
            state   <= CONVERT;
            sar_rst <= 1'b0;
            timer   <= '0;
          end else begin
            samp_cnt <= samp_cnt - 1'b1;
          end
        end

        CONVERT: begin
          if (eoc) begin
            acc      <= acc_next;
            conv_cnt <= conv_cnt + 1'b1;
            sar_rst  <= 1'b1;
            if (last_conv) begin
              state <= DONE;
            end else begin
              state    <= SAMPLE;
              samp_cnt <= samp_load;
            end
          end else if (timer == TW'(TIMEOUT - 1)) begin
            // Abort: accumulated codes are discarded on the way through IDLE.
            timeout_err <= 1'b1;
            sar_rst     <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        DONE: begin
          if (out_free) begin
            res.result       <= avg;
            res.result_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
          acc      <= '0;
          conv_cnt <= '0;
          if (cont_en) begin
            state    <= SAMPLE;
            samp_cnt <= samp_load;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          sar_rst <= 1'b1;
          busy    <= 1'b0;
        end
      endcase

      if (clr_flags) begin
        overrun     <= 1'b0;
        timeout_err <= 1'b0;
      end
    end
  end

endmodule
